multdiv_hazard_ctrl: RTL and testbench
======================================

Name: multdiv_hazard_ctrl

Overview:
- Pipeline controller for the 5-stage core. Sits beside the bypass network in the DX stage.
- Sequences the multicycle mult/div unit: issues a start pulse, freezes FD/DX while the unit is busy, and steers the result (or an exception status) into the XM latch.
- Also detects load-use hazards that bypassing cannot cover, and inserts a one-cycle bubble for them.

Parameters:
- MAX_CYCLES, 40: BUSY-cycle limit before the operation is forced complete as an exception.
- CNT_W, 6: cycle counter width; requires 2^CNT_W > MAX_CYCLES.
- STATUS_MUL, 4: rstatus value written on a mult overflow or timeout.
- STATUS_DIV, 5: rstatus value written on a div-by-zero or timeout.

Ports:
- clock  in  1  rising-edge clock; sole clock domain
- reset  in  1  synchronous, active-high
- fd_insn  in  32  instruction in the FD latch
- dx_insn  in  32  instruction in the DX latch
- md_ready  in  1  mult/div result valid (data_resultRDY)
- md_exception  in  1  mult/div exception; meaningful only with md_ready
- ctrl_mult  out  1  one-cycle start pulse to the multiplier
- ctrl_div  out  1  one-cycle start pulse to the divider
- stall_fd  out  1  hold PC and the FD latch
- stall_dx  out  1  hold the DX latch
- nop_dx  out  1  load a nop into DX this edge
- nop_xm  out  1  load a nop into XM this edge
- md_busy  out  1  operation in flight (START or BUSY)
- md_done  out  1  XM latch captures the mult/div result instead of the ALU result
- md_exc_wr  out  1  with md_done: write md_status to r30 instead of the result
- md_rd  out  5  destination register for the mult/div writeback
- md_status  out  32  zero-extended STATUS_MUL or STATUS_DIV when md_exc_wr, else 0

Behaviour:
- Decode:
  - opcode = [31:27], rd = [26:22], rs1 = [21:17], rs2 = [16:12], aluop = [6:2].
  - mul: opcode 00000 with aluop 00110. div: opcode 00000 with aluop 00111. lw: opcode 01000.
- FSM states: IDLE, BUSY, DONE.
- Reset: state = IDLE, counter = 0, op/rd/exc registers = 0. All outputs 0 in the reset cycle and in the following IDLE cycle unless a detect condition holds.
- IDLE:
  - If dx is mul or div, in the same cycle:
    - pulse ctrl_mult or ctrl_div;
    - assert stall_fd, stall_dx, nop_xm, md_busy;
    - latch op type and dx rd; clear counter;
    - next state = BUSY.
  - Otherwise, if load-use, assert stall_fd and nop_dx for that cycle only; state stays IDLE. Load-use holds when all of:
    - dx is lw and dx rd != 0;
    - fd reads a matching register: rs1 for r-type/addi/sw/lw/bne/blt, rs2 for r-type except shifts (aluop 0010x), rd for bne/blt/jr.
    - sw data (rd) is excluded; the WM bypass covers it.
  - md_ready is ignored in IDLE.
- BUSY:
  - Assert stall_fd, stall_dx, nop_xm, md_busy. The counter increments each cycle.
  - No further ctrl_* pulses are issued.
  - If md_ready: latch exc = md_exception; next state = DONE.
  - Else if counter == MAX_CYCLES-1: latch exc = 1; next state = DONE (timeout).
  - md_ready and timeout in the same cycle: md_ready wins, and exc takes md_exception.
- DONE, exactly one cycle:
  - md_done = 1; stalls deasserted, so DX advances into XM.
  - md_rd = latched rd, or 30 if exc.
  - md_exc_wr = exc; md_status = STATUS_MUL or STATUS_DIV by op type.
  - Next state = IDLE. The new dx insn is evaluated there, so back-to-back mul/div incurs no extra idle cycle beyond DONE.
  - Load-use detection is suppressed in DONE.
- Latency: start pulse at cycle 0; md_done in the cycle after md_ready is sampled high.
- rd = 0 on mul/div: sequenced normally; md_rd = 0 and the register file discards the write.
- Reset mid-BUSY: returns to IDLE next edge, with no md_done and no pulse. The external unit is reset by the same signal.

Test Plan:
- dx = mul r3,r1,r2; md_ready high at BUSY cycle 32 -> exactly one ctrl_mult pulse; stall_fd/stall_dx high 33 cycles; next cycle md_done=1, md_rd=3, md_exc_wr=0.
- div r5,r1,r0 with md_exception=1 at md_ready -> md_done=1, md_exc_wr=1, md_rd=30, md_status=5.
- dx = lw r4,0(r2); fd = add r6,r4,r7 -> one cycle of stall_fd=1, nop_dx=1. Repeat with fd = sw r4,0(r9) -> no stall.
- md_ready never asserted -> after 40 BUSY cycles, DONE with md_exc_wr=1 and md_status=4 (mul).
- mul immediately followed by div -> ctrl_mult, then after DONE, ctrl_div on the next cycle; ctrl_* are never high together.
- reset at BUSY cycle 10 -> all outputs 0 next cycle; a later md_ready produces no md_done.

Source files
------------

// File: rtl/multdiv_hazard_ctrl_if.sv
// Pipeline-side bundle for the mult/div hazard controller: FD/DX instructions, mult/div handshake,
// and the stall/nop/writeback-steering controls. The controller connects through the slave modport.
interface multdiv_hazard_ctrl_if;
    logic [31:0] fd_insn;
    logic [31:0] dx_insn;
    logic        md_ready;
    logic        md_exception;
    logic        ctrl_mult;
    logic        ctrl_div;
    logic        stall_fd;
    logic        stall_dx;
    logic        nop_dx;
    logic        nop_xm;
    logic        md_busy;
    logic        md_done;
    logic        md_exc_wr;
    logic [4:0]  md_rd;
    logic [31:0] md_status;

    modport master (
        output fd_insn, dx_insn, md_ready, md_exception,
        input  ctrl_mult, ctrl_div, stall_fd, stall_dx, nop_dx, nop_xm,
        input  md_busy, md_done, md_exc_wr, md_rd, md_status
    );

    modport slave (
        input  fd_insn, dx_insn, md_ready, md_exception,
        output ctrl_mult, ctrl_div, stall_fd, stall_dx, nop_dx, nop_xm,
        output md_busy, md_done, md_exc_wr, md_rd, md_status
    );
endinterface

// File: rtl/multdiv_hazard_ctrl.sv
// DX-stage controller: sequences the multicycle mult/div unit (start pulse, freeze, result or
// exception steering into XM) and inserts a one-cycle bubble for uncovered load-use hazards.
module multdiv_hazard_ctrl #(
    parameter int unsigned MAX_CYCLES = 40,
    parameter int unsigned CNT_W      = 6,
    parameter int unsigned STATUS_MUL = 4,
    parameter int unsigned STATUS_DIV = 5
) (
    input logic                  clock,
    input logic                  reset,
    multdiv_hazard_ctrl_if.slave pipe
);
    localparam logic [4:0] OpRType = 5'b00000;
    localparam logic [4:0] OpBne   = 5'b00010;
    localparam logic [4:0] OpJr    = 5'b00100;
    localparam logic [4:0] OpAddi  = 5'b00101;
    localparam logic [4:0] OpBlt   = 5'b00110;
    localparam logic [4:0] OpSw    = 5'b00111;
    localparam logic [4:0] OpLw    = 5'b01000;
    localparam logic [4:0] AluMul  = 5'b00110;
    localparam logic [4:0] AluDiv  = 5'b00111;
    localparam logic [4:0] RegExc  = 5'd30;

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    state_e           state;
    logic [CNT_W-1:0] cnt;
    logic             op_div;
    logic [4:0]       rd;
    logic             exc;

    logic [4:0] dx_op, dx_rd, dx_aluop;
    logic [4:0] fd_op, fd_rd, fd_rs1, fd_rs2, fd_aluop;
    logic       dx_mul, dx_div, dx_md, dx_lw;
    logic       fd_rtype, fd_shift, reads_rs1, reads_rs2, reads_rd, load_use;
    logic       unused_bits;

    assign dx_op    = pipe.dx_insn[31:27];
    assign dx_rd    = pipe.dx_insn[26:22];
    assign dx_aluop = pipe.dx_insn[6:2];
    assign fd_op    = pipe.fd_insn[31:27];
    assign fd_rd    = pipe.fd_insn[26:22];
    assign fd_rs1   = pipe.fd_insn[21:17];
    assign fd_rs2   = pipe.fd_insn[16:12];
    assign fd_aluop = pipe.fd_insn[6:2];

    assign unused_bits = ^{pipe.dx_insn[21:7], pipe.dx_insn[1:0],
                           pipe.fd_insn[11:7], pipe.fd_insn[1:0]};

    assign dx_mul = (dx_op == OpRType) && (dx_aluop == AluMul);
    assign dx_div = (dx_op == OpRType) && (dx_aluop == AluDiv);
    assign dx_md  = dx_mul || dx_div;
    assign dx_lw  = (dx_op == OpLw);

    // sw data (rd) is deliberately absent: the WM bypass forwards it.
    assign fd_rtype  = (fd_op == OpRType);
    assign fd_shift  = fd_rtype && (fd_aluop[4:1] == 4'b0010);
    assign reads_rs1 = fd_rtype || (fd_op == OpAddi) || (fd_op == OpSw) || (fd_op == OpLw)
                    || (fd_op == OpBne) || (fd_op == OpBlt);
    assign reads_rs2 = fd_rtype && !fd_shift;
    assign reads_rd  = (fd_op == OpBne) || (fd_op == OpBlt) || (fd_op == OpJr);

    assign load_use = dx_lw && (dx_rd != 5'd0)
                   && ((reads_rs1 && (fd_rs1 == dx_rd))
                    || (reads_rs2 && (fd_rs2 == dx_rd))
                    || (reads_rd  && (fd_rd  == dx_rd)));

    always_ff @(posedge clock) begin
        if (reset) begin
            state  <= StIdle;
            cnt    <= '0;
            op_div <= 1'b0;
            rd     <= 5'd0;
            exc    <= 1'b0;
        end else begin
            unique case (state)
                StIdle: begin
                    if (dx_md) begin
                        state  <= StBusy;
                        cnt    <= '0;
                        op_div <= dx_div;
                        rd     <= dx_rd;
                    end
                end
                StBusy: begin
                    cnt <= cnt + CNT_W'(1);
                    // A real result outranks a coincident timeout.
                    if (pipe.md_ready) begin
                        exc   <= pipe.md_exception;
                        state <= StDone;
                    end else if (cnt == CNT_W'(MAX_CYCLES - 1)) begin
                        exc   <= 1'b1;
                        state <= StDone;
                    end
                end
                StDone:  state <= StIdle;
                default: state <= StIdle;
            endcase
        end
    end

    always_comb begin
        pipe.ctrl_mult = 1'b0;
        pipe.ctrl_div  = 1'b0;
        pipe.stall_fd  = 1'b0;
        pipe.stall_dx  = 1'b0;
        pipe.nop_dx    = 1'b0;
        pipe.nop_xm    = 1'b0;
        pipe.md_busy   = 1'b0;
        pipe.md_done   = 1'b0;
        pipe.md_exc_wr = 1'b0;
        pipe.md_rd     = 5'd0;
        pipe.md_status = 32'd0;
        if (!reset) begin
            unique case (state)
                StIdle: begin
                    if (dx_md) begin
                        pipe.ctrl_mult = dx_mul;
                        pipe.ctrl_div  = dx_div;
                        pipe.stall_fd  = 1'b1;
                        pipe.stall_dx  = 1'b1;
                        pipe.nop_xm    = 1'b1;
                        pipe.md_busy   = 1'b1;
                    end else if (load_use) begin
                        pipe.stall_fd = 1'b1;
                        pipe.nop_dx   = 1'b1;
                    end
                end
                StBusy: begin
                    pipe.stall_fd = 1'b1;
                    pipe.stall_dx = 1'b1;
                    pipe.nop_xm   = 1'b1;
                    pipe.md_busy  = 1'b1;
                end
                StDone: begin
                    pipe.md_done   = 1'b1;
                    pipe.md_exc_wr = exc;
                    pipe.md_rd     = exc ? RegExc : rd;
                    if (exc) pipe.md_status = op_div ? 32'(STATUS_DIV) : 32'(STATUS_MUL);
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_multdiv_hazard_ctrl.sv
// Directed bench for multdiv_hazard_ctrl: mult/div sequencing, exceptions, timeout,
// back-to-back ops, load-use bubbles and reset mid-operation.
module tb_multdiv_hazard_ctrl;
    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    multdiv_hazard_ctrl_if pipe();

    multdiv_hazard_ctrl #(
        .MAX_CYCLES(40),
        .CNT_W(6),
        .STATUS_MUL(4),
        .STATUS_DIV(5)
    ) dut (
        .clock(clock),
        .reset(reset),
        .pipe(pipe)
    );

    // Output vector order: ctrl_mult ctrl_div stall_fd stall_dx nop_dx nop_xm md_busy md_done md_exc_wr
    localparam logic [8:0] OutsNone     = 9'b000000000;
    localparam logic [8:0] OutsMulStart = 9'b101101100;
    localparam logic [8:0] OutsDivStart = 9'b011101100;
    localparam logic [8:0] OutsLoadUse  = 9'b001010000;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

    function automatic logic [8:0] outs();
        return {pipe.ctrl_mult, pipe.ctrl_div, pipe.stall_fd, pipe.stall_dx, pipe.nop_dx,
                pipe.nop_xm, pipe.md_busy, pipe.md_done, pipe.md_exc_wr};
    endfunction

    function automatic logic [31:0] rtype(input int rd, input int rs1, input int rs2,
                                          input int aluop);
        return {5'b00000, 5'(rd), 5'(rs1), 5'(rs2), 5'b00000, 5'(aluop), 2'b00};
    endfunction

    function automatic logic [31:0] itype(input int op, input int rd, input int rs, input int imm);
        return {5'(op), 5'(rd), 5'(rs), 17'(imm)};
    endfunction

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    // Holds insn in DX from the start cycle until md_done is seen (bounded); cycle 0 is the start.
    task automatic run_md(input logic [31:0] insn, input int ready_at, input logic exc_in,
                          output logic [8:0] start, output int n_mult, output int n_div,
                          output int n_stall, output int n_overlap, output int done_at);
        n_mult = 0; n_div = 0; n_stall = 0; n_overlap = 0; done_at = -1; start = '0;
        for (int c = 0; c < 60; c++) begin
            cyc();
            pipe.dx_insn      = insn;
            pipe.md_ready     = (c == ready_at);
            pipe.md_exception = exc_in && (c == ready_at);
            @(negedge clock);
            if (c == 0) start = outs();
            n_mult    += int'(pipe.ctrl_mult);
            n_div     += int'(pipe.ctrl_div);
            n_stall   += int'(pipe.stall_fd && pipe.stall_dx);
            n_overlap += int'(pipe.ctrl_mult && pipe.ctrl_div);
            if (pipe.md_done) begin
                done_at = c;
                break;
            end
        end
        pipe.md_ready     = 1'b0;
        pipe.md_exception = 1'b0;
    endtask

    logic [31:0] nop_i, mul3, div5_zero, div5, lw4, lw0;
    logic [8:0]  start;
    int          n_mult, n_div, n_stall, n_overlap, done_at, overlap_total;

    initial begin
        nop_i     = 32'd0;
        mul3      = rtype(3, 1, 2, 6);
        div5_zero = rtype(5, 1, 0, 7);
        div5      = rtype(5, 1, 2, 7);
        lw4       = itype(8, 4, 2, 0);
        lw0       = itype(8, 0, 2, 0);

        reset             = 1'b1;
        pipe.fd_insn      = nop_i;
        pipe.dx_insn      = mul3;
        pipe.md_ready     = 1'b0;
        pipe.md_exception = 1'b0;
        @(negedge clock);
        check("reset_outs", 32'(outs()), 32'(OutsNone));
        check("reset_md_rd", 32'(pipe.md_rd), 32'd0);
        check("reset_status", pipe.md_status, 32'd0);

        cyc();
        reset        = 1'b0;
        pipe.dx_insn = nop_i;
        @(negedge clock);
        check("idle_outs", 32'(outs()), 32'(OutsNone));

        // mul r3,r1,r2 with md_ready at BUSY cycle 32
        run_md(mul3, 32, 1'b0, start, n_mult, n_div, n_stall, n_overlap, done_at);
        check("mul_start_outs", 32'(start), 32'(OutsMulStart));
        check("mul_pulses", n_mult, 1);
        check("mul_div_pulses", n_div, 0);
        check("mul_stall_cycles", n_stall, 33);
        check("mul_done_at", done_at, 33);
        check("mul_done_outs", 32'(outs()), 32'b000000010);
        check("mul_md_rd", 32'(pipe.md_rd), 32'd3);
        check("mul_status", pipe.md_status, 32'd0);
        cyc();
        pipe.dx_insn = nop_i;
        @(negedge clock);
        check("mul_after_idle", 32'(outs()), 32'(OutsNone));

        // div r5,r1,r0 reporting divide-by-zero
        run_md(div5_zero, 10, 1'b1, start, n_mult, n_div, n_stall, n_overlap, done_at);
        check("div_start_outs", 32'(start), 32'(OutsDivStart));
        check("div_pulses", n_div, 1);
        check("div_done_at", done_at, 11);
        check("div_exc_outs", 32'(outs()), 32'b000000011);
        check("div_exc_rd", 32'(pipe.md_rd), 32'd30);
        check("div_exc_status", pipe.md_status, 32'd5);

        // mul with md_ready never arriving: 40 BUSY cycles, then timeout exception
        cyc();
        pipe.dx_insn = nop_i;
        @(negedge clock);
        run_md(mul3, -1, 1'b0, start, n_mult, n_div, n_stall, n_overlap, done_at);
        check("tmo_done_at", done_at, 41);
        check("tmo_stall_cycles", n_stall, 41);
        check("tmo_pulses", n_mult, 1);
        check("tmo_exc_wr", 32'(pipe.md_exc_wr), 32'd1);
        check("tmo_rd", 32'(pipe.md_rd), 32'd30);
        check("tmo_status", pipe.md_status, 32'd4);

        // mul immediately followed by div: div pulse right after DONE
        cyc();
        pipe.dx_insn = nop_i;
        @(negedge clock);
        run_md(mul3, 5, 1'b0, start, n_mult, n_div, n_stall, n_overlap, done_at);
        overlap_total = n_overlap;
        check("b2b_mul_done_at", done_at, 6);
        check("b2b_mul_rd", 32'(pipe.md_rd), 32'd3);
        run_md(div5, 3, 1'b0, start, n_mult, n_div, n_stall, n_overlap, done_at);
        overlap_total += n_overlap;
        check("b2b_div_start", 32'(start), 32'(OutsDivStart));
        check("b2b_div_mult_pulses", n_mult, 0);
        check("b2b_div_done_at", done_at, 4);
        check("b2b_div_rd", 32'(pipe.md_rd), 32'd5);
        check("b2b_div_exc_wr", 32'(pipe.md_exc_wr), 32'd0);
        check("b2b_overlap", overlap_total, 0);

        // load-use cases: {dx, fd, expected outputs}
        begin
            logic [31:0] lu_dx [6];
            logic [31:0] lu_fd [6];
            logic [8:0]  lu_exp [6];
            lu_dx[0] = lw4; lu_fd[0] = rtype(6, 4, 7, 0);  lu_exp[0] = OutsLoadUse;
            lu_dx[1] = lw4; lu_fd[1] = itype(7, 4, 9, 0);  lu_exp[1] = OutsNone;
            lu_dx[2] = lw4; lu_fd[2] = itype(2, 4, 9, 0);  lu_exp[2] = OutsLoadUse;
            lu_dx[3] = lw4; lu_fd[3] = rtype(6, 7, 4, 4);  lu_exp[3] = OutsNone;
            lu_dx[4] = lw4; lu_fd[4] = rtype(6, 7, 4, 1);  lu_exp[4] = OutsLoadUse;
            lu_dx[5] = lw0; lu_fd[5] = rtype(6, 0, 7, 0);  lu_exp[5] = OutsNone;
            for (int i = 0; i < 6; i++) begin
                cyc();
                pipe.dx_insn = lu_dx[i];
                pipe.fd_insn = lu_fd[i];
                @(negedge clock);
                check($sformatf("load_use_%0d", i), 32'(outs()), 32'(lu_exp[i]));
                cyc();
                pipe.dx_insn = nop_i;
                @(negedge clock);
                check($sformatf("load_use_%0d_after", i), 32'(outs()), 32'(OutsNone));
            end
            pipe.fd_insn = nop_i;
        end

        // reset at BUSY cycle 10, then a stray md_ready must not produce md_done
        for (int c = 0; c <= 10; c++) begin
            cyc();
            pipe.dx_insn = mul3;
            reset        = (c == 10);
            @(negedge clock);
            if (c == 9) check("rst_busy_before", 32'(pipe.md_busy), 32'd1);
        end
        check("rst_mid_outs", 32'(outs()), 32'(OutsNone));
        cyc();
        reset        = 1'b0;
        pipe.dx_insn = nop_i;
        @(negedge clock);
        check("rst_after_outs", 32'(outs()), 32'(OutsNone));
        cyc();
        pipe.md_ready = 1'b1;
        @(negedge clock);
        check("rst_ready_ignored", 32'(outs()), 32'(OutsNone));
        cyc();
        pipe.md_ready = 1'b0;
        @(negedge clock);
        check("rst_no_done", 32'(pipe.md_done), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
